// File: rtl/bounce_sprites.sv
// Bouncing-box screensaver: NUM_BOXES sprites swept once per frame, rendered from registered state.
// Define BOUNCE_BG_TINT_EN to tint the background dimly with box 0's colour instead of black.
module bounce_sprites #(
    parameter int unsigned SCREEN_WIDTH  = 640,
    parameter int unsigned SCREEN_HEIGHT = 480,
    parameter int unsigned NUM_BOXES     = 3,
    parameter int unsigned BOX_WIDTH     = 100,
    parameter int unsigned BOX_HEIGHT    = 100,
    parameter int unsigned SPEED_X       = 2,
    parameter int unsigned SPEED_Y       = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [$clog2(SCREEN_WIDTH)-1:0]  position_x,
    input  logic [$clog2(SCREEN_HEIGHT)-1:0] position_y,
    input  logic [31:0]                      frame,
    input  logic                             pause,
    output logic [3:0]                       r,
    output logic [3:0]                       g,
    output logic [3:0]                       b,
    output logic                             busy,
    output logic [15:0]                      bounce_count
);

    localparam int unsigned XW    = $clog2(SCREEN_WIDTH);
    localparam int unsigned YW    = $clog2(SCREEN_HEIGHT);
    localparam int unsigned IW    = (NUM_BOXES > 1) ? $clog2(NUM_BOXES) : 1;
    localparam int unsigned MAX_X = SCREEN_WIDTH - BOX_WIDTH;
    localparam int unsigned MAX_Y = SCREEN_HEIGHT - BOX_HEIGHT;

    typedef enum logic [0:0] {StIdle, StSweep} state_e;

    function automatic logic [XW-1:0] init_x(input int unsigned i);
        int unsigned v;
        v = 50 + 60 * i;
        if (v > MAX_X) v = MAX_X;
        return XW'(v);
    endfunction

    function automatic logic [YW-1:0] init_y(input int unsigned i);
        int unsigned v;
        v = 50 + 40 * i;
        if (v > MAX_Y) v = MAX_Y;
        return YW'(v);
    endfunction

    function automatic logic [2:0] init_color(input int unsigned i);
        return 3'((i % 7) + 1);
    endfunction

    state_e                 state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic                   pending_q, pending_d;
    logic [31:0]            frame_prev_q;
    logic [15:0]            bounce_q, bounce_d;
    logic [XW-1:0]          x_q [NUM_BOXES];
    logic [XW-1:0]          x_d [NUM_BOXES];
    logic [YW-1:0]          y_q [NUM_BOXES];
    logic [YW-1:0]          y_d [NUM_BOXES];
    logic [2:0]             color_q [NUM_BOXES];
    logic [2:0]             color_d [NUM_BOXES];
    logic [NUM_BOXES-1:0]   dir_x_q, dir_x_d;
    logic [NUM_BOXES-1:0]   dir_y_q, dir_y_d;

    logic [XW-1:0] cur_x, nx;
    logic [YW-1:0] cur_y, ny;
    logic [2:0]    cur_c, nc;
    logic          cur_dx, cur_dy, ndx, ndy, hit_x, hit_y;

    // Box currently addressed by the sweep and its one-step successor.
    always_comb begin
        cur_x  = x_q[0];
        cur_y  = y_q[0];
        cur_c  = color_q[0];
        cur_dx = dir_x_q[0];
        cur_dy = dir_y_q[0];
        for (int unsigned i = 0; i < NUM_BOXES; i++) begin
            if (idx_q == IW'(i)) begin
                cur_x  = x_q[i];
                cur_y  = y_q[i];
                cur_c  = color_q[i];
                cur_dx = dir_x_q[i];
                cur_dy = dir_y_q[i];
            end
        end

        nx    = cur_x;
        ndx   = cur_dx;
        hit_x = 1'b0;
        if (cur_dx) begin
            if ({1'b0, cur_x} + (XW+1)'(SPEED_X) >= (XW+1)'(MAX_X)) begin
                nx    = XW'(MAX_X);
                ndx   = 1'b0;
                hit_x = 1'b1;
            end else begin
                nx = cur_x + XW'(SPEED_X);
            end
        end else if ({1'b0, cur_x} <= (XW+1)'(SPEED_X)) begin
            nx    = '0;
            ndx   = 1'b1;
            hit_x = 1'b1;
        end else begin
            nx = cur_x - XW'(SPEED_X);
        end

        ny    = cur_y;
        ndy   = cur_dy;
        hit_y = 1'b0;
        if (cur_dy) begin
            if ({1'b0, cur_y} + (YW+1)'(SPEED_Y) >= (YW+1)'(MAX_Y)) begin
                ny    = YW'(MAX_Y);
                ndy   = 1'b0;
                hit_y = 1'b1;
            end else begin
                ny = cur_y + YW'(SPEED_Y);
            end
        end else if ({1'b0, cur_y} <= (YW+1)'(SPEED_Y)) begin
            ny    = '0;
            ndy   = 1'b1;
            hit_y = 1'b1;
        end else begin
            ny = cur_y - YW'(SPEED_Y);
        end

        nc = cur_c;
        if (hit_x || hit_y) nc = (cur_c == 3'd7) ? 3'd1 : cur_c + 3'd1;
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pending_d = pending_q;
        bounce_d  = bounce_q;
        x_d       = x_q;
        y_d       = y_q;
        color_d   = color_q;
        dir_x_d   = dir_x_q;
        dir_y_d   = dir_y_q;

        unique case (state_q)
            StIdle: begin
                if (pending_q) begin
                    pending_d = 1'b0;
                    // A paused frame is consumed without motion.
                    if (!pause) begin
                        state_d = StSweep;
                        idx_d   = '0;
                    end
                end
            end
            StSweep: begin
                for (int unsigned i = 0; i < NUM_BOXES; i++) begin
                    if (idx_q == IW'(i)) begin
                        x_d[i]     = nx;
                        y_d[i]     = ny;
                        color_d[i] = nc;
                        dir_x_d[i] = ndx;
                        dir_y_d[i] = ndy;
                    end
                end
                if (hit_x || hit_y) bounce_d = bounce_q + 16'd1;
                if (idx_q == IW'(NUM_BOXES - 1)) state_d = StIdle;
                else                             idx_d   = idx_q + IW'(1);
            end
            default: state_d = StIdle;
        endcase

        if (frame != frame_prev_q) pending_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            pending_q    <= 1'b0;
            frame_prev_q <= 32'hFFFF_FFFF;
            bounce_q     <= '0;
            for (int unsigned i = 0; i < NUM_BOXES; i++) begin
                x_q[i]     <= init_x(i);
                y_q[i]     <= init_y(i);
                color_q[i] <= init_color(i);
                dir_x_q[i] <= (i % 2 == 0);
                dir_y_q[i] <= 1'b1;
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            pending_q    <= pending_d;
            frame_prev_q <= frame;
            bounce_q     <= bounce_d;
            x_q          <= x_d;
            y_q          <= y_d;
            color_q      <= color_d;
            dir_x_q      <= dir_x_d;
            dir_y_q      <= dir_y_d;
        end
    end

    logic       in_any;
    logic [2:0] win_c;

    // Scan from the top index down so the lowest-index box wins overlaps.
    always_comb begin
        in_any = 1'b0;
        win_c  = '0;
        for (int i = int'(NUM_BOXES) - 1; i >= 0; i--) begin
            if (position_x >= x_q[i] &&
                {1'b0, position_x} < {1'b0, x_q[i]} + (XW+1)'(BOX_WIDTH) &&
                position_y >= y_q[i] &&
                {1'b0, position_y} < {1'b0, y_q[i]} + (YW+1)'(BOX_HEIGHT)) begin
                in_any = 1'b1;
                win_c  = color_q[i];
            end
        end

        if (in_any) begin
            r = {4{win_c[0]}};
            g = {4{win_c[1]}};
            b = {4{win_c[2]}};
        end else begin
`ifdef BOUNCE_BG_TINT_EN
            r = 4'b0001 & {4{color_q[0][0]}};
            g = 4'b0001 & {4{color_q[0][1]}};
            b = 4'b0001 & {4{color_q[0][2]}};
`else
            r = 4'b0000;
            g = 4'b0000;
            b = 4'b0000;
`endif
        end
    end

    assign busy         = (state_q == StSweep);
    assign bounce_count = bounce_q;

endmodule
